// File: rtl/ps2_scan_fifo.sv
// PS/2 keyboard receiver feeding a first-word-fall-through scan-code FIFO.
// Latency: raw clock fall to bit sample is 2 + FILTER cycles; a good byte is visible one cycle after its stop-bit sample.
// Backpressure: none towards the keyboard; a good byte arriving while full is dropped and flagged in overflow.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   ps2_clk, ps2_data   raw asynchronous PS/2 pins (treated as data, never driven)
//   rd                  one-cycle pop strobe; ignored when empty
//   clr                 clears the sticky overflow and frame_err flags
//   dout, empty, count  registered FIFO head (0 when empty), empty flag, fill level
//   overflow, frame_err sticky error flags
//   status              {empty, overflow, frame_err, 5'b0, dout} for direct readback
module ps2_scan_fifo #(
  parameter int DEPTH   = 16,
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 200000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ps2_clk,
  input  logic                     ps2_data,
  input  logic                     rd,
  input  logic                     clr,
  output logic [7:0]               dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     frame_err,
  output logic [15:0]              status
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  // ---------------- synchroniser and glitch filter ----------------
  logic          clk_s1, clk_s2, data_s1, data_s2;
  logic          fclk, fclk_prev;
  logic [FW-1:0] filt_cnt;
  logic          fall;
  logic          bit_in;

  // Sync flops reset to the idle-high line level so reset never creates an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1  <= 1'b1;
      clk_s2  <= 1'b1;
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
    end
  end

  // fclk only follows after FILTER consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      fclk      <= 1'b1;
      fclk_prev <= 1'b1;
      filt_cnt  <= '0;
    end else begin
      fclk_prev <= fclk;
      if (clk_s2 == fclk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FW'(FILTER - 1)) begin
        fclk     <= clk_s2;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + FW'(1);
      end
    end
  end

  assign fall   = fclk_prev & ~fclk;
  assign bit_in = data_s2;

  // ---------------- frame FSM ----------------
  state_t        state_q, state_d;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_ok;
  logic [TW-1:0] idle_cnt;
  logic          timeout;
  logic          push_req;
  logic          err_set;

  // A fall in the same cycle as expiry counts as activity, not a timeout.
  assign timeout = (state_q != S_IDLE) && !fall && (idle_cnt == TW'(TIMEOUT));

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = S_IDLE;
    end else if (fall) begin
      case (state_q)
        S_IDLE:   if (!bit_in) state_d = S_DATA;
        S_DATA:   if (bit_idx == 3'd7) state_d = S_PARITY;
        S_PARITY: state_d = S_STOP;
        S_STOP:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    push_req = 1'b0;
    err_set  = timeout;
    if (fall) begin
      if (state_q == S_IDLE && bit_in)
        err_set = 1'b1;
      if (state_q == S_STOP) begin
        push_req = bit_in & par_ok;
        err_set  = ~(bit_in & par_ok);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_idx  <= '0;
      shreg    <= '0;
      par_ok   <= 1'b0;
      idle_cnt <= '0;
    end else begin
      if (state_q == S_IDLE || fall || timeout) idle_cnt <= '0;
      else                                      idle_cnt <= idle_cnt + TW'(1);
      if (fall) begin
        case (state_q)
          S_IDLE:   bit_idx <= '0;
          S_DATA: begin
            shreg   <= {bit_in, shreg[7:1]};  // LSB arrives first
            bit_idx <= bit_idx + 3'd1;
          end
          S_PARITY: par_ok <= ^{shreg, bit_in};  // odd parity over data + parity bit
          default:  ;
        endcase
      end
    end
  end

  // ---------------- FWFT FIFO ----------------
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, next_rd;
  logic [CW-1:0] count_q, next_cnt;
  logic [7:0]    dout_q, head_d;
  logic          full, pop, push_ok, ovf_set;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = rd & ~empty;
  assign push_ok = push_req & (~full | pop);  // a same-cycle pop frees the slot
  assign ovf_set = push_req & full & ~pop;
  assign next_rd = pop ? rd_ptr + AW'(1) : rd_ptr;

  always_comb begin
    next_cnt = count_q;
    if (push_ok && !pop)      next_cnt = count_q + CW'(1);
    else if (!push_ok && pop) next_cnt = count_q - CW'(1);
  end

  // The new head bypasses memory when it is the byte being written right now.
  always_comb begin
    if (next_cnt == '0)                   head_d = 8'h00;
    else if (push_ok && next_rd == wr_ptr) head_d = shreg;
    else                                   head_d = mem[next_rd];
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      dout_q    <= 8'h00;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr  <= next_rd;
      count_q <= next_cnt;
      dout_q  <= head_d;
      // Set has priority over clear.
      if (ovf_set)  overflow  <= 1'b1;
      else if (clr) overflow  <= 1'b0;
      if (err_set)  frame_err <= 1'b1;
      else if (clr) frame_err <= 1'b0;
    end
  end

  assign dout   = dout_q;
  assign count  = count_q;
  assign status = {empty, overflow, frame_err, 5'b0, dout_q};

endmodule

// File: tb/tb_ps2_scan_fifo.sv
module tb_ps2_scan_fifo;
  localparam int DEPTH   = 16;
  localparam int FILTER  = 8;
  localparam int TIMEOUT = 500;
  localparam int HALF    = 20;   // PS/2 half period in clk cycles

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        rd = 1'b0;
  logic        clr = 1'b0;
  logic [7:0]  dout;
  logic        empty;
  logic [4:0]  count;
  logic        overflow;
  logic        frame_err;
  logic [15:0] status;

  ps2_scan_fifo #(.DEPTH(DEPTH), .FILTER(FILTER), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd(rd), .clr(clr), .dout(dout), .empty(empty), .count(count),
    .overflow(overflow), .frame_err(frame_err), .status(status)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: byte queue plus two sticky flags.
  logic [7:0] q[$];
  logic       m_ovf = 1'b0;
  logic       m_ferr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [7:0] ed;
    logic       ee;
    ee = (q.size() == 0);
    ed = ee ? 8'h00 : q[0];
    chk({tag, ".count"},  32'(count),     32'(q.size()));
    chk({tag, ".dout"},   32'(dout),      32'(ed));
    chk({tag, ".empty"},  32'(empty),     32'(ee));
    chk({tag, ".ovf"},    32'(overflow),  32'(m_ovf));
    chk({tag, ".ferr"},   32'(frame_err), 32'(m_ferr));
    chk({tag, ".status"}, 32'(status),    {16'h0, ee, m_ovf, m_ferr, 5'b0, ed});
  endtask

  // Sends the first nbits of a frame; a short frame is followed by a stall past TIMEOUT.
  task automatic send(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                      input logic glitch, input logic rd_at_stop, input int nbits);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk) ps2_data = bits[i];
      if (glitch) begin
        repeat (5) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (HALF - 8) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b0;
      if (i == 10 && rd_at_stop) begin
        // 2 sync + FILTER cycles put the stop-bit sample cycle here
        repeat (2 + FILTER) @(negedge clk);
        rd = 1'b1;
        @(negedge clk) rd = 1'b0;
        repeat (HALF - 3 - FILTER) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    if (nbits < 11) begin
      repeat (TIMEOUT + 10) @(negedge clk);
      m_ferr = 1'b1;
    end else begin
      repeat (2 * HALF) @(negedge clk);
      if (rd_at_stop && q.size() > 0) void'(q.pop_front());
      if (!bad_par && !bad_stop) begin
        if (q.size() < DEPTH) q.push_back(b);
        else                  m_ovf = 1'b1;
      end else begin
        m_ferr = 1'b1;
      end
    end
  endtask

  task automatic good(input logic [7:0] b);
    send(b, 1'b0, 1'b0, 1'b0, 1'b0, 11);
  endtask

  task automatic pop();
    @(negedge clk) rd = 1'b1;
    @(negedge clk) rd = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic do_clr();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  logic [7:0] rb;
  int         kind;
  int         npop;

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    check_all("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // single good frame
    good(8'h1C);
    check_all("single");
    pop();
    check_all("single_pop");

    // break sequence
    good(8'hF0);
    good(8'h1C);
    check_all("break");
    pop();
    check_all("break_pop1");
    pop();
    check_all("break_pop2");
    pop();
    check_all("pop_empty");

    // error frames
    send(8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 11);
    check_all("bad_parity");
    do_clr();
    check_all("clr");
    send(8'h33, 1'b0, 1'b1, 1'b0, 1'b0, 11);
    check_all("bad_stop");
    do_clr();

    // overflow
    for (int i = 0; i <= DEPTH; i++) good(8'(i));
    check_all("overflow");
    for (int i = 0; i < DEPTH; i++) begin
      pop();
      check_all("drain");
    end
    do_clr();

    // timeout, then glitch-immune good frame
    send(8'h77, 1'b0, 1'b0, 1'b0, 1'b0, 5);
    check_all("timeout");
    do_clr();
    for (int g = 0; g < 3; g++) begin
      @(negedge clk) ps2_clk = 1'b0;
      repeat (3) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (10) @(negedge clk);
    end
    check_all("idle_glitch");
    send(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 11);
    check_all("after_timeout");
    pop();

    // simultaneous push and pop while full
    for (int i = 0; i < DEPTH; i++) good(8'($urandom));
    check_all("full");
    send(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 11);
    check_all("full_pushpop");
    for (int i = 0; i < DEPTH; i++) begin
      pop();
      check_all("full_drain");
    end

    // simultaneous push and pop with one entry
    good(8'h11);
    send(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 11);
    check_all("one_pushpop");
    pop();

    // reset mid-drain
    good(8'h3C);
    good(8'h4D);
    pop();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    q.delete();
    m_ovf  = 1'b0;
    m_ferr = 1'b0;
    check_all("reset_mid");

    // randomized traffic
    for (int it = 0; it < 20; it++) begin
      rb   = 8'($urandom);
      kind = $urandom_range(0, 5);
      send(rb, kind == 0, kind == 1, 1'($urandom), 1'b0, 11);
      check_all("rand_frame");
      npop = $urandom_range(0, 2);
      for (int p = 0; p < npop; p++) begin
        pop();
        check_all("rand_pop");
      end
      if ($urandom_range(0, 3) == 0) begin
        do_clr();
        check_all("rand_clr");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
